// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control path: FSM states, opcode/func
// constants, ALU operation codes, mux selects and the control-word struct.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MREAD  = 4'd3,
        S_MWB    = 4'd4,
        S_MWRITE = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pcsrc;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic       extop;
        logic [3:0] aluop;
        logic       regdst;
        logic       regwrite;
        logic       mem2reg;
        logic       instr_done;
        logic       fault;
        logic [1:0] fault_code;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type func field to ALU operation, with a flag for supported functions.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] func_i,
    output logic [3:0] aluop_o,
    output logic       legal_o
);

    always_comb begin
        aluop_o = ALU_ADD;
        legal_o = 1'b1;
        case (func_i)
            FN_ADD:  aluop_o = ALU_ADD;
            FN_SUB:  aluop_o = ALU_SUB;
            FN_AND:  aluop_o = ALU_AND;
            FN_OR:   aluop_o = ALU_OR;
            FN_SLT:  aluop_o = ALU_SLT;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences instruction phases over a shared
// ALU and memory port, with a bounded wait on memory and a sticky fault state.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pcsrc,
    output logic       alusrc_a,
    output logic [1:0] alusrc_b,
    output logic       extop,
    output logic [3:0] aluop,
    output logic       regdst,
    output logic       regwrite,
    output logic       mem2reg,
    output logic       instr_done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [3:0] state
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fcode_q, fcode_d;
    logic [3:0]       rtype_aluop;
    logic             rtype_legal;
    logic             mem_state;
    logic             timeout;
    ctrl_t            ctl, ctl_out;

    mips_alu_decode u_alu_decode (
        .func_i  (func),
        .aluop_o (rtype_aluop),
        .legal_o (rtype_legal)
    );

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MREAD) || (state_q == S_MWRITE);
    // A late mem_ready on the limit cycle still completes the access.
    assign timeout   = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LIMIT) && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            fcode_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcode_q <= fcode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcode_d = fcode_q;
        ctl     = '0;
        case (state_q)
            S_FETCH: begin
                ctl.memread  = 1'b1;
                ctl.alusrc_b = ALUB_FOUR;
                ctl.aluop    = ALU_ADD;
                ctl.pcsrc    = PCSRC_ALU;
                ctl.ir_write = mem_ready;
                ctl.pc_write = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                    fcode_d = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                ctl.alusrc_b = ALUB_IMM_SH2;
                ctl.extop    = 1'b1;
                ctl.aluop    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MADDR;
                    OP_RTYPE:     state_d = rtype_legal ? S_REXEC : S_FAULT;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_IEXEC;
                    default:      state_d = S_FAULT;
                endcase
                if (state_d == S_FAULT) fcode_d = FC_ILLEGAL;
            end
            S_MADDR: begin
                ctl.alusrc_a = 1'b1;
                ctl.alusrc_b = ALUB_IMM;
                ctl.extop    = 1'b1;
                ctl.aluop    = ALU_ADD;
                state_d      = (opcode == OP_LW) ? S_MREAD : S_MWRITE;
            end
            S_MREAD, S_MWRITE: begin
                ctl.iord     = 1'b1;
                ctl.memread  = (state_q == S_MREAD);
                ctl.memwrite = (state_q == S_MWRITE);
                if (mem_ready) begin
                    ctl.instr_done = (state_q == S_MWRITE);
                    state_d        = (state_q == S_MREAD) ? S_MWB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_FAULT;
                    fcode_d = FC_TIMEOUT;
                end
            end
            S_MWB: begin
                ctl.regwrite   = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_REXEC: begin
                ctl.alusrc_a = 1'b1;
                ctl.alusrc_b = ALUB_REG;
                ctl.aluop    = rtype_aluop;
                state_d      = S_RWB;
            end
            S_RWB: begin
                ctl.regwrite   = 1'b1;
                ctl.regdst     = 1'b1;
                ctl.mem2reg    = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alusrc_a   = 1'b1;
                ctl.alusrc_b   = ALUB_REG;
                ctl.aluop      = ALU_SUB;
                ctl.pcsrc      = PCSRC_ALUOUT;
                ctl.pc_write   = zero_flag;
                ctl.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                ctl.pcsrc      = PCSRC_JUMP;
                ctl.pc_write   = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_IEXEC: begin
                ctl.alusrc_a = 1'b1;
                ctl.alusrc_b = ALUB_IMM;
                ctl.extop    = 1'b1;
                ctl.aluop    = ALU_ADD;
                state_d      = S_IWB;
            end
            S_IWB: begin
                ctl.regwrite   = 1'b1;
                ctl.mem2reg    = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_FAULT: begin
                ctl.fault      = 1'b1;
                ctl.fault_code = fcode_q;
            end
            default: begin
                state_d = S_FAULT;
                fcode_d = FC_ILLEGAL;
            end
        endcase
    end

    // Wait counter restarts on every state change and saturates while stalled.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (mem_state && !mem_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign ctl_out    = rst ? '0 : ctl;
    assign iord       = ctl_out.iord;
    assign memread    = ctl_out.memread;
    assign memwrite   = ctl_out.memwrite;
    assign ir_write   = ctl_out.ir_write;
    assign pc_write   = ctl_out.pc_write;
    assign pcsrc      = ctl_out.pcsrc;
    assign alusrc_a   = ctl_out.alusrc_a;
    assign alusrc_b   = ctl_out.alusrc_b;
    assign extop      = ctl_out.extop;
    assign aluop      = ctl_out.aluop;
    assign regdst     = ctl_out.regdst;
    assign regwrite   = ctl_out.regwrite;
    assign mem2reg    = ctl_out.mem2reg;
    assign instr_done = ctl_out.instr_done;
    assign fault      = ctl_out.fault;
    assign fault_code = ctl_out.fault_code;
    assign state      = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction phase lists produce the
// expected per-cycle control word, which a monitor compares on falling edges.
module tb_mips_multicycle_ctrl;

    localparam int TMO = 16;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MADDR = 2, ST_MREAD = 3, ST_MWB = 4;
    localparam int ST_MWRITE = 5, ST_REXEC = 6, ST_RWB = 7, ST_BRANCH = 8, ST_JUMP = 9;
    localparam int ST_IEXEC = 10, ST_IWB = 11, ST_FAULT = 12, ST_RESET = 99;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       zero_flag = 1'b0;
    logic       mem_ready = 1'b0;
    logic       iord, memread, memwrite, ir_write, pc_write, alusrc_a, extop;
    logic       regdst, regwrite, mem2reg, instr_done, fault;
    logic [1:0] pcsrc, alusrc_b, fault_code;
    logic [3:0] aluop, state;

    logic [25:0] exp_q[$];
    logic [25:0] mon_exp, mon_act;
    int          checks = 0;
    int          passes = 0;
    int          cycle_n = 0;

    logic [5:0]  cur_op = '0;
    logic [5:0]  cur_fn = '0;
    logic [1:0]  m_fc = 2'b00;
    int          zf_sel = 2;
    logic [5:0]  legal_fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func       (func),
        .zero_flag  (zero_flag),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memread    (memread),
        .memwrite   (memwrite),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pcsrc      (pcsrc),
        .alusrc_a   (alusrc_a),
        .alusrc_b   (alusrc_b),
        .extop      (extop),
        .aluop      (aluop),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .mem2reg    (mem2reg),
        .instr_done (instr_done),
        .fault      (fault),
        .fault_code (fault_code),
        .state      (state)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic coin();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'd2;
            6'h22:   return 4'd6;
            6'h24:   return 4'd0;
            6'h25:   return 4'd1;
            6'h2a:   return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h02 || op == 6'h08) return 1'b1;
        if (op == 6'h00) begin
            foreach (legal_fns[i]) if (legal_fns[i] == fn) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected control word for one cycle spent in phase st.
    function automatic logic [25:0] outv(input int st, input logic mr, input logic zf,
                                         input logic [5:0] fn, input logic [1:0] fc);
        logic [3:0] s, aop;
        logic io, mrd, mwr, irw, pcw, asa, ext, rdst, rw, m2r, done, flt;
        logic [1:0] psrc, asb, fcd;
        {io, mrd, mwr, irw, pcw, asa, ext, rdst, rw, m2r, done, flt} = '0;
        psrc = '0; asb = '0; fcd = '0; aop = '0;
        s = (st == ST_RESET) ? 4'd0 : st[3:0];
        case (st)
            ST_FETCH:  begin mrd = 1; asb = 2'b01; aop = 4'd2; irw = mr; pcw = mr; end
            ST_DECODE: begin asb = 2'b11; ext = 1; aop = 4'd2; end
            ST_MADDR:  begin asa = 1; asb = 2'b10; ext = 1; aop = 4'd2; end
            ST_MREAD:  begin mrd = 1; io = 1; end
            ST_MWB:    begin rw = 1; done = 1; end
            ST_MWRITE: begin mwr = 1; io = 1; done = mr; end
            ST_REXEC:  begin asa = 1; aop = alu_of(fn); end
            ST_RWB:    begin rw = 1; rdst = 1; m2r = 1; done = 1; end
            ST_BRANCH: begin asa = 1; aop = 4'd6; psrc = 2'b01; pcw = zf; done = 1; end
            ST_JUMP:   begin psrc = 2'b10; pcw = 1; done = 1; end
            ST_IEXEC:  begin asa = 1; asb = 2'b10; ext = 1; aop = 4'd2; end
            ST_IWB:    begin rw = 1; m2r = 1; done = 1; end
            ST_FAULT:  begin flt = 1; fcd = fc; end
            default:   ;
        endcase
        return {s, io, mrd, mwr, irw, pcw, psrc, asa, asb, ext, aop, rdst, rw, m2r, done, flt, fcd};
    endfunction

    // driver tasks: each call covers exactly one clock cycle
    task automatic cyc(input int st, input logic mr);
        rst       = 1'b0;
        opcode    = cur_op;
        func      = cur_fn;
        mem_ready = mr;
        zero_flag = (zf_sel == 2) ? coin() : zf_sel[0];
        exp_q.push_back(outv(st, mr, zero_flag, cur_fn, m_fc));
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst       = 1'b1;
            mem_ready = coin();
            zero_flag = coin();
            exp_q.push_back(outv(ST_RESET, 1'b0, 1'b0, 6'h0, 2'b00));
            @(posedge clk); #1;
        end
        m_fc = 2'b00;
    endtask

    task automatic fault_hold(input int n);
        for (int i = 0; i < n; i++) cyc(ST_FAULT, coin());
        do_reset(2);
    endtask

    // waits = stalled cycles before mem_ready; the (TMO+1)th stall faults.
    task automatic mem_phase(input int st, input int waits, output bit ok);
        ok = 1'b0;
        for (int c = 0; c <= TMO; c++) begin
            cyc(st, c == waits);
            if (c == waits) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        bit ok;
        cur_op = op;
        cur_fn = fn;
        mem_phase(ST_FETCH, fw, ok);
        if (!ok) begin m_fc = 2'b10; fault_hold(3); return; end
        cyc(ST_DECODE, coin());
        if (!is_legal(op, fn)) begin m_fc = 2'b01; fault_hold(3); return; end
        case (op)
            6'h23: begin
                cyc(ST_MADDR, coin());
                mem_phase(ST_MREAD, mw, ok);
                if (!ok) begin m_fc = 2'b10; fault_hold(3); return; end
                cyc(ST_MWB, coin());
            end
            6'h2b: begin
                cyc(ST_MADDR, coin());
                mem_phase(ST_MWRITE, mw, ok);
                if (!ok) begin m_fc = 2'b10; fault_hold(3); return; end
            end
            6'h00:   begin cyc(ST_REXEC, coin()); cyc(ST_RWB, coin()); end
            6'h04:   cyc(ST_BRANCH, coin());
            6'h02:   cyc(ST_JUMP, coin());
            default: begin cyc(ST_IEXEC, coin()); cyc(ST_IWB, coin()); end
        endcase
    endtask

    function automatic int rnd_wait();
        if ($urandom_range(0, 19) == 0) return int'($urandom_range(TMO - 1, TMO + 1));
        return int'($urandom_range(0, 2));
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        cycle_n++;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {state, iord, memread, memwrite, ir_write, pc_write, pcsrc, alusrc_a,
                       alusrc_b, extop, aluop, regdst, regwrite, mem2reg, instr_done, fault, fault_code};
            checks++;
            if (mon_act === mon_exp) passes++;
            else $display("FAIL ctrl_word cycle %0d (state %0d): got %h expected %h",
                          cycle_n, mon_exp[25:22], mon_act, mon_exp);
        end
    end

    initial begin
        logic [5:0] op, fn;
        int k;
        @(posedge clk); #1;
        do_reset(2);

        // add, zero-wait memory
        run_instr(6'h00, 6'h20, 0, 0);
        // lw with three stalled MREAD cycles
        run_instr(6'h23, 6'h00, 0, 3);
        // beq taken then not taken
        zf_sel = 1; run_instr(6'h04, 6'h00, 0, 0);
        zf_sel = 0; run_instr(6'h04, 6'h00, 0, 0);
        zf_sel = 2;
        run_instr(6'h2b, 6'h00, 1, 2);
        run_instr(6'h02, 6'h00, 0, 0);
        run_instr(6'h08, 6'h00, 0, 0);
        foreach (legal_fns[i]) run_instr(6'h00, legal_fns[i], 0, 0);

        // reset in the middle of a read, then of a write
        cur_op = 6'h23;
        cyc(ST_FETCH, 1); cyc(ST_DECODE, 0); cyc(ST_MADDR, 0); cyc(ST_MREAD, 0); cyc(ST_MREAD, 0);
        do_reset(2);
        cur_op = 6'h2b;
        cyc(ST_FETCH, 1); cyc(ST_DECODE, 0); cyc(ST_MADDR, 0); cyc(ST_MWRITE, 0);
        do_reset(2);
        run_instr(6'h00, 6'h22, 0, 0);

        // illegal opcode and illegal R-type func
        run_instr(6'h3f, 6'h20, 0, 0);
        run_instr(6'h00, 6'h00, 0, 0);

        // timeout boundaries: fault after TMO stalls, ready on the limit cycle wins
        run_instr(6'h00, 6'h20, TMO + 1, 0);
        run_instr(6'h00, 6'h20, TMO, 0);
        run_instr(6'h23, 6'h00, 10, TMO);
        run_instr(6'h23, 6'h00, 0, TMO + 1);
        run_instr(6'h2b, 6'h00, 0, TMO + 1);
        run_instr(6'h2b, 6'h00, 0, TMO);

        for (int n = 0; n < 150; n++) begin
            k = int'($urandom_range(0, 9));
            fn = legal_fns[$urandom_range(0, 4)];
            case (k)
                0, 9: op = 6'h23;
                1:    op = 6'h2b;
                2, 3, 4: op = 6'h00;
                5:    op = 6'h04;
                6:    op = 6'h02;
                7:    op = 6'h08;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    fn = 6'($urandom_range(0, 63));
                    if (is_legal(op, fn)) op = 6'h3f;
                end
            endcase
            run_instr(op, fn, rnd_wait(), rnd_wait());
        end

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
